// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU front end.
// Contents: base opcode constants, the reset NOP word, the fetch-state enum,
// instruction field bit positions and an I-type immediate helper.
package cpu_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFull
  } fetch_state_e;

  localparam int unsigned OpcodeLsb = 0;
  localparam int unsigned OpcodeW   = 7;
  localparam int unsigned RdLsb     = 7;
  localparam int unsigned RegW      = 5;
  localparam int unsigned Funct3Lsb = 12;
  localparam int unsigned Funct3W   = 3;
  localparam int unsigned Rs1Lsb    = 15;
  localparam int unsigned Rs2Lsb    = 20;
  localparam int unsigned Funct7Lsb = 25;
  localparam int unsigned Funct7W   = 7;
  localparam int unsigned ImmILsb   = 20;
  localparam int unsigned ImmIW     = 12;

  function automatic logic [31:0] sext_i_imm(input logic [31:0] insn);
    return {{(32 - ImmIW){insn[31]}}, insn[ImmILsb +: ImmIW]};
  endfunction

endpackage

// File: rtl/ir_decode.sv
// Pure combinational field extraction from an instruction word.
// Ports:
//   ir_i      instruction word
//   opcode_o  [6:0], rd_o [11:7], funct3_o [14:12], rs1_o [19:15],
//   rs2_o     [24:20], funct7_o [31:25]
//   imm_o     sign-extended I-type immediate
module ir_decode
  import cpu_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [6:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [6:0]  funct7_o,
  output logic [31:0] imm_o
);

  assign opcode_o = ir_i[OpcodeLsb +: OpcodeW];
  assign rd_o     = ir_i[RdLsb +: RegW];
  assign funct3_o = ir_i[Funct3Lsb +: Funct3W];
  assign rs1_o    = ir_i[Rs1Lsb +: RegW];
  assign rs2_o    = ir_i[Rs2Lsb +: RegW];
  assign funct7_o = ir_i[Funct7Lsb +: Funct7W];
  assign imm_o    = sext_i_imm(ir_i);

endmodule

// File: rtl/if_unit.sv
// Instruction-fetch stage: owns the PC, prefetches the word at PC into a
// one-entry buffer over a ready-handshaked memory port, loads IR on IR_Write
// and advances PC by 4 on PC_Write.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   PC_Write, IR_Write    control-unit strobes
//   imem_req/addr         request held until imem_ready
//   imem_rdata/ready      response, data valid only with ready
//   PC, IR_PC, IR         next-load address, address of IR, instruction
//   opcode..imm           decoded fields of IR
//   ir_valid, ir_stall    IR holds a fetched word; IR_Write waiting on memory
module if_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = cpu_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_Write,
  input  logic        IR_Write,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PC,
  output logic [31:0] IR_PC,
  output logic [31:0] IR,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        ir_valid,
  output logic        ir_stall
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  ir_pc_q, ir_pc_d;
  logic         ir_valid_q, ir_valid_d;
  logic         pend_q, pend_d;   // IR_Write accepted, waiting for memory
  logic         stale_q, stale_d; // outstanding response belongs to an old PC
  logic         pend_now;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_d      = buf_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    pend_d     = pend_q;
    stale_d    = stale_q;
    pend_now   = pend_q | IR_Write;

    if (PC_Write) begin
      pc_d = pc_q + 32'd4;
    end

    unique case (state_q)
      StIdle: begin
        state_d    = StFetch;
        req_addr_d = pc_d;
        pend_d     = pend_now;
      end
      StFetch: begin
        pend_d  = pend_now;
        stale_d = stale_q | PC_Write;
        if (imem_ready) begin
          stale_d = 1'b0;
          if (stale_q) begin
            // Drop the response and reissue at the current PC right away.
            req_addr_d = pc_d;
          end else begin
            if (pend_now) begin
              ir_d       = imem_rdata;
              ir_pc_d    = req_addr_q;
              ir_valid_d = 1'b1;
              pend_d     = 1'b0;
            end
            if (PC_Write) begin
              // Word belongs to the PC just left behind; fetch the new one.
              req_addr_d = pc_d;
            end else begin
              state_d = StFull;
              buf_d   = imem_rdata;
            end
          end
        end
      end
      StFull: begin
        if (IR_Write) begin
          ir_d       = buf_q;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
        end
        if (PC_Write) begin
          state_d    = StFetch;
          req_addr_d = pc_d;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_q      <= NOP_INSN;
      ir_q       <= NOP_INSN;
      ir_pc_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
      pend_q     <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      pend_q     <= pend_d;
      stale_q    <= stale_d;
    end
  end

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = req_addr_q;
  assign PC        = pc_q;
  assign IR_PC     = ir_pc_q;
  assign IR        = ir_q;
  assign ir_valid  = ir_valid_q;
  // Any IR_Write outside FULL has to wait for the memory.
  assign ir_stall  = pend_q | (IR_Write & (state_q != StFull));

  ir_decode u_ir_decode (
    .ir_i     (ir_q),
    .opcode_o (opcode),
    .rd_o     (rd),
    .funct3_o (funct3),
    .rs1_o    (rs1),
    .rs2_o    (rs2),
    .funct7_o (funct7),
    .imm_o    (imm)
  );

endmodule

// File: tb/tb_if_unit.sv
`timescale 1ns/1ps
module tb_if_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_Write, IR_Write;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PC, IR_PC, IR, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        ir_valid, ir_stall;

  // Second instance parked at the top of the address space for the wrap case.
  logic        w_pcw, w_irw, w_req, w_ready, w_valid, w_stall;
  logic [31:0] w_addr, w_rdata, w_pc, w_ir_pc, w_ir, w_imm;
  logic [6:0]  w_opcode, w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  if_unit dut (
    .clk(clk), .rst(rst), .PC_Write(PC_Write), .IR_Write(IR_Write),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .PC(PC), .IR_PC(IR_PC), .IR(IR), .opcode(opcode),
    .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
    .ir_valid(ir_valid), .ir_stall(ir_stall)
  );

  if_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .PC_Write(w_pcw), .IR_Write(w_irw),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .imem_ready(w_ready), .PC(w_pc), .IR_PC(w_ir_pc), .IR(w_ir), .opcode(w_opcode),
    .rd(w_rd), .funct3(w_funct3), .rs1(w_rs1), .rs2(w_rs2), .funct7(w_funct7),
    .imm(w_imm), .ir_valid(w_valid), .ir_stall(w_stall)
  );

  assign w_ready = w_req;
  assign w_rdata = memf(w_addr);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] pc_model;

  // Issue strobes for the current cycle; every accepted IR_Write expects the
  // word at the PC current when it was issued.
  task automatic drive(input bit pcw, input bit irw);
    exp_t e;
    PC_Write = pcw;
    IR_Write = irw;
    if (irw) begin
      e.addr = pc_model;
      e.word = memf(pc_model);
      sbq.push_back(e);
    end
    if (pcw) pc_model = pc_model + 32'd4;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory model: fixed or random wait count per request.
  bit mem_en    = 1'b1;
  bit rand_wait = 1'b0;
  int fixed_wait = 0;

  initial begin
    int cnt, lim;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    cnt = 0;
    lim = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        if (imem_req) begin
          if (cnt == 0) lim = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
          if (cnt >= lim) begin
            imem_ready = 1'b1;
            imem_rdata = memf(imem_addr);
            cnt = 0;
          end else begin
            imem_ready = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            cnt++;
          end
        end else begin
          imem_ready = 1'b0;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: an IR load is visible after a non-stalled IR_Write or when
  // ir_stall drops; each load pops one expectation.
  bit mon_en = 1'b0;

  initial begin
    logic        p_stall, p_irw, p_req, p_rdy;
    logic [31:0] p_addr;
    exp_t        e;
    p_stall = 1'b0;
    p_irw   = 1'b0;
    p_req   = 1'b0;
    p_rdy   = 1'b0;
    p_addr  = 32'h0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if ((p_irw && !p_stall) || (p_stall && !ir_stall)) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_load: got IR=%h expected no load", IR);
          end else begin
            e = sbq.pop_front();
            check("ir", IR, e.word);
            check("ir_pc", IR_PC, e.addr);
            check("ir_valid", 32'(ir_valid), 32'd1);
            check("opcode", 32'(opcode), 32'(e.word[6:0]));
            check("rd", 32'(rd), 32'(e.word[11:7]));
            check("funct3", 32'(funct3), 32'(e.word[14:12]));
            check("rs1", 32'(rs1), 32'(e.word[19:15]));
            check("rs2", 32'(rs2), 32'(e.word[24:20]));
            check("funct7", 32'(funct7), 32'(e.word[31:25]));
            check("imm", imm, {{20{e.word[31]}}, e.word[31:20]});
          end
        end
        if (p_req && !p_rdy) begin
          check("req_held", 32'(imem_req), 32'd1);
          check("addr_stable", imem_addr, p_addr);
        end
      end
      p_stall = ir_stall;
      p_irw   = IR_Write;
      p_req   = imem_req;
      p_rdy   = imem_ready;
      p_addr  = imem_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, PC, 32'h0);
    check({tag, "_ir_pc"}, IR_PC, 32'h0);
    check({tag, "_ir"}, IR, 32'h0000_0013);
    check({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
    check({tag, "_ir_stall"}, 32'(ir_stall), 32'd0);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    int n, k, r;
    rst = 1'b1;
    PC_Write = 1'b0;
    IR_Write = 1'b0;
    w_pcw = 1'b0;
    w_irw = 1'b0;
    pc_model = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");

    // Release; request rises in the second cycle after release.
    cyc(); rst = 1'b0; mon_en = 1'b1;          // A
    @(negedge clk); check("req_cycle1", 32'(imem_req), 32'd0);
    cyc();                                     // B
    @(negedge clk);
    check("req_cycle2", 32'(imem_req), 32'd1);
    check("req_addr0", imem_addr, 32'h0);
    cyc();                                     // C: FULL
    drive(1'b1, 1'b1);
    @(negedge clk); check("full_no_req", 32'(imem_req), 32'd0);
    cyc(); drive(1'b0, 1'b0);                  // D
    @(negedge clk);
    check("first_ir", IR, 32'h0050_0093);
    check("pc_after", PC, 32'd4);
    check("first_rd", 32'(rd), 32'd1);
    check("first_imm", imm, 32'd5);
    check("first_valid", 32'(ir_valid), 32'd1);

    // PC_Write alone during a 2-wait fetch of address 8.
    cyc(); fixed_wait = 2; drive(1'b1, 1'b0);  // E: FULL at 4
    cyc(); drive(1'b1, 1'b0);                  // F: fetch 8, PC -> 12
    @(negedge clk); check("stale_addr_f", imem_addr, 32'd8);
    cyc(); drive(1'b0, 1'b0);                  // G
    @(negedge clk); check("stale_addr_g", imem_addr, 32'd8);
    cyc();                                     // H: ready
    @(negedge clk);
    check("stale_addr_h", imem_addr, 32'd8);
    check("stale_ready_h", 32'(imem_ready), 32'd1);
    cyc();                                     // I: reissue
    @(negedge clk);
    check("reissue_req", 32'(imem_req), 32'd1);
    check("reissue_addr", imem_addr, 32'd12);
    check("ir_unchanged", IR, 32'h0050_0093);
    cyc(); cyc(); cyc();                       // L: FULL at 12

    // IR_Write twice in FULL without PC_Write.
    drive(1'b0, 1'b1);
    @(negedge clk); check("twice_no_req1", 32'(imem_req), 32'd0);
    cyc(); drive(1'b0, 1'b0);
    cyc(); drive(1'b0, 1'b1);
    cyc(); drive(1'b0, 1'b0);
    @(negedge clk);
    check("twice_pc", PC, 32'd12);
    check("twice_no_req2", 32'(imem_req), 32'd0);

    // IR_Write in the first cycle of a 3-wait fetch; second pulse absorbed.
    cyc(); fixed_wait = 3; drive(1'b1, 1'b0);
    cyc(); drive(1'b0, 1'b1);                  // fetch 16, cycle 1
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ir_stall) n++;
      cyc();
      if (i == 1) IR_Write = 1'b0;
    end
    check("stall_cycles", 32'(n), 32'd4);
    check("stall_pc", PC, 32'd16);
    check("stall_full", 32'(imem_req), 32'd0);

    // Reset in the middle of a request; ready during reset is ignored.
    drive(1'b1, 1'b0);
    cyc(); drive(1'b0, 1'b0);
    mon_en = 1'b0;
    mem_en = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_req", 32'(imem_req), 32'd1);
    check("sb_empty_pre_rst", 32'(sbq.size()), 32'd0);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    cyc();
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    cyc();
    imem_ready = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_ready");
    cyc();
    rst = 1'b0;
    mem_en = 1'b1;
    fixed_wait = 0;
    pc_model = 32'h0;
    mon_en = 1'b1;
    cyc(); cyc(); cyc();

    // Randomized traffic against the model.
    rand_wait = 1'b1;
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        drive(1'b0, 1'b1);
        #1;
        if (!ir_stall && r == 0) begin
          PC_Write = 1'b1;
          pc_model = pc_model + 32'd4;
        end
        cyc();
        IR_Write = 1'b0;
        PC_Write = 1'b0;
        k = 0;
        while (ir_stall && k < 40) begin
          cyc();
          k++;
        end
        if (k >= 40) begin
          total++;
          bad++;
          $display("FAIL stall_timeout: got ir_stall=1 expected 0 within 40 cycles");
        end
      end else if (r < 6) begin
        drive(1'b1, 1'b0);
        cyc();
        PC_Write = 1'b0;
      end else begin
        cyc();
      end
      check("rand_pc", PC, pc_model);
    end
    repeat (4) cyc();
    check("sb_drained", 32'(sbq.size()), 32'd0);

    // Wrap: FFFF_FFFC + 4 -> 0, then fetch of address 0.
    w_pcw = 1'b1;
    cyc();
    w_pcw = 1'b0;
    @(negedge clk);
    check("wrap_pc", w_pc, 32'h0);
    check("wrap_req", 32'(w_req), 32'd1);
    check("wrap_addr", w_addr, 32'h0);
    cyc();
    w_irw = 1'b1;
    cyc();
    w_irw = 1'b0;
    @(negedge clk);
    check("wrap_ir", w_ir, 32'h0050_0093);
    check("wrap_ir_pc", w_ir_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
